// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a two-entry skid buffer,
// stall/flush/freeze controls and saturating stall/flush event counters.
module pipe_stage_reg #(
    parameter int                 DATA_W  = 64,
    parameter logic [DATA_W-1:0]  NOP_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   main_data_r;
    logic [DATA_W-1:0]   main_nxt_s;
    logic [DATA_W-1:0]   skid_data_r;
    logic [DATA_W-1:0]   skid_nxt_s;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [CNT_W-1:0]    flush_cnt_r;

    logic main_valid_s;
    logic skid_valid_s;
    logic in_ready_s;
    logic in_fire_s;
    logic out_fire_s;
    logic stall_inc_s;
    logic flush_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign main_valid_s = (state_r == ST_FULL) || (state_r == ST_SKID);
    assign skid_valid_s = (state_r == ST_SKID);
    // Gated by rst_i so upstream sees "not ready" for as long as reset is held.
    assign in_ready_s   = rst_i & ~skid_valid_s & ~freeze_i;
    assign in_fire_s    = in_valid_i & in_ready_s & ~flush_i;
    assign out_fire_s   = main_valid_s & out_ready_i & ~stall_i & ~freeze_i & ~flush_i;
    assign stall_inc_s  = main_valid_s & ~out_fire_s & ~freeze_i & ~flush_i;
    assign flush_inc_s  = flush_i & ~freeze_i;

    assign in_ready_o   = in_ready_s;
    assign out_valid_o  = main_valid_s;
    assign out_data_o   = main_valid_s ? main_data_r : NOP_VAL;
    assign stall_cnt_o  = stall_cnt_r;
    assign flush_cnt_o  = flush_cnt_r;

    // Next-state and payload selection; freeze outranks flush, flush outranks traffic.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_data_r;
        skid_nxt_s  = skid_data_r;
        if (freeze_i) begin
            state_nxt_s = state_r;
        end else if (flush_i) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = NOP_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = in_data_i;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        main_nxt_s  = in_data_i;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                        main_nxt_s  = NOP_VAL;
                    end else if (in_fire_s) begin
                        state_nxt_s = ST_SKID;
                        skid_nxt_s  = in_data_i;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_fire_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = skid_data_r;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = NOP_VAL;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_EMPTY;
            main_data_r <= NOP_VAL;
            skid_data_r <= NOP_VAL;
        end else begin
            state_r     <= state_nxt_s;
            main_data_r <= main_nxt_s;
            skid_data_r <= skid_nxt_s;
        end
    end

    // Saturating performance event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline registers (IF/ID, ID/EX, ...).
- Generic DATA_W payload; valid/ready handshake on both sides.
- Two-entry skid buffer, so upstream is never combinationally stalled by downstream ready.
- Keeps the existing stall / flush / global-freeze (cache miss) controls.
- Adds saturating stall and flush event counters for performance debug.
- Sits between any two CPU pipeline stages.

Parameters:
DATA_W, 64, payload width (e.g. PC + instruction).
NOP_VAL, {DATA_W{1'b0}}, value driven on out_data_o when the stage holds no valid beat.
CNT_W, 16, width of each event counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-low reset.
in_valid_i  input  1  upstream beat valid.
in_data_i  input  DATA_W  upstream payload.
in_ready_o  output  1  stage can accept a beat this cycle.
stall_i  input  1  hazard hold from the hazard unit; blocks the output transfer only.
flush_i  input  1  discard all held beats and the incoming beat.
freeze_i  input  1  global CPU stall (memory/cache miss); freezes the entire block.
out_valid_o  output  1  output beat valid.
out_data_o  output  DATA_W  output payload.
out_ready_i  input  1  downstream accepts.
stall_cnt_o  output  CNT_W  cycles with a valid output not transferred.
flush_cnt_o  output  CNT_W  number of flush events.

Behaviour:
- Reset (rst_i=0, async):
  - main_valid=0, skid_valid=0, main_data=NOP_VAL.
  - Counters=0, out_valid_o=0, out_data_o=NOP_VAL, in_ready_o=0 while reset is asserted.
  - Reset mid-transfer drops every beat.
- Internal state:
  - Main entry drives the outputs.
  - Skid entry holds one overflow beat.
  - States: EMPTY (neither valid), FULL (main only), SKID (both valid).
  - SKID without main is illegal.
- Combinational signals:
  - in_ready_o = ~skid_valid & ~freeze_i.
  - out_valid_o = main_valid.
  - out_data_o = main_data when main_valid, else NOP_VAL.
- Fire conditions:
  - in_fire = in_valid_i & in_ready_o & ~flush_i.
  - out_fire = main_valid & out_ready_i & ~stall_i & ~freeze_i & ~flush_i.
- Priority per edge: reset > freeze_i > flush_i > normal transitions.
- freeze_i=1: no state, data or counter changes. Any flush_i or stall_i asserted in the same cycle is ignored.
- flush_i=1 (freeze_i=0):
  - Next state EMPTY; main_data <= NOP_VAL.
  - The incoming beat is consumed and discarded (in_ready_o reflects the normal rule).
  - flush_cnt increments.
- Normal transitions:
  - EMPTY: in_fire -> FULL, main<=in_data_i.
  - FULL: in_fire & out_fire -> FULL, main<=in_data_i.
  - FULL: out_fire only -> EMPTY, main_data<=NOP_VAL.
  - FULL: in_fire only -> SKID, skid<=in_data_i.
  - FULL: neither -> hold.
  - SKID: out_fire -> FULL, main<=skid.
  - SKID: otherwise hold. in_ready_o=0, so no input is accepted.
- Timing and ordering:
  - Latency 1 cycle from in_fire (EMPTY) to out_valid_o.
  - Throughput 1 beat/cycle.
  - Strict FIFO order; no beat is duplicated or lost except by flush or reset.
- stall_cnt:
  - Increments when main_valid & ~out_fire & ~freeze_i & ~flush_i.
  - This covers cycles blocked by stall_i or by out_ready_i=0.
- Counters saturate at all-ones; no wrap.

Test Plan:
- Reset then stream: rst_i low 2 cycles; out_valid_o=0, out_data_o=0. Then feed 0x11,0x22,0x33 back-to-back with out_ready_i=1 -> identical values appear one cycle later, one per cycle, in_ready_o stays 1.
- Skid fill: hold out_ready_i=0, feed 0xA,0xB,0xC -> 0xA in main, 0xB in skid, in_ready_o=0 during the 0xC cycle. Release -> outputs 0xA, 0xB, then 0xC after it is re-presented. stall_cnt equals the blocked cycles.
- Stall vs freeze: in FULL with 0x5, stall_i=1 for 3 cycles -> output held, stall_cnt +3. Then freeze_i=1 plus flush_i=1 for 2 cycles -> nothing changes, flush_cnt unchanged, in_ready_o=0.
- Flush in SKID with in_valid_i=1 (0x77) -> next cycle out_valid_o=0, out_data_o=NOP_VAL, flush_cnt=1, 0x77 never appears.
- Saturation: CNT_W=2, hold the stall for 6 cycles -> stall_cnt_o=3 and stays 3.
- Async reset mid-SKID: rst_i low between edges -> outputs clear immediately, not on the next edge.
